// File: rtl/fifo_wr_ingress_pkg.sv
// Shared FIFO definitions used by both the write and the read side.
// Pointer helpers work on a 32-bit container; callers truncate to their width.
package fifo_wr_ingress_pkg;

   localparam int unsigned PTR_MAX        = 32;
   localparam int unsigned P_SIZE_DEFAULT = 4;

   typedef logic [PTR_MAX-1:0] ptr_t;

   function automatic int unsigned depth_of(input int unsigned p_size);
      return 32'd1 << (p_size - 1);
   endfunction

   localparam int unsigned DEPTH = depth_of(P_SIZE_DEFAULT);

   // Zero-extended Gray input leaves the low bits of the result exact.
   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[PTR_MAX-1] = g[PTR_MAX-1];
      for (int unsigned i = PTR_MAX - 1; i > 0; i--) begin
         b[i-1] = b[i] ^ g[i-1];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_wr_ingress_if.sv
// Upstream valid/ready word interface feeding the FIFO write ingress.
interface fifo_wr_ingress_if #(
   parameter int unsigned D_WIDTH = 8
);
   logic               s_valid;
   logic [D_WIDTH-1:0] s_data;
   logic               s_ready;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/fifo_wr_ingress_sync_2ff.sv
// Two-flop synchroniser, width-parameterised, reset to zero.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/fifo_wr_ingress.sv
// FIFO write-side ingress: read-pointer sync, skid-buffered upstream port,
// write strobe generation, fill level, almost-full and write counter.
module fifo_wr_ingress
   import fifo_wr_ingress_pkg::*;
#(
   parameter int unsigned P_SIZE   = 4,
   parameter int unsigned D_WIDTH  = 8,
   parameter int unsigned AF_LEVEL = 6
) (
   input  logic                w_clk,
   input  logic                w_rstn,
   fifo_wr_ingress_if.slave    up,
   input  logic [P_SIZE-1:0]   rd_gray_ptr,
   input  logic [P_SIZE-1:0]   w_ptr,
   input  logic                full,
   output logic [P_SIZE-1:0]   sync_rd_ptr,
   output logic                w_inc,
   output logic [D_WIDTH-1:0]  w_data,
   output logic [P_SIZE-1:0]   w_level,
   output logic                almost_full,
   output logic [15:0]         wr_count
);
   localparam int unsigned FIFO_DEPTH = depth_of(P_SIZE);

   logic [P_SIZE-1:0]  rd_bin;
   logic [P_SIZE-1:0]  lvl;
   logic               xfer;
   logic               ready_q;
   logic               main_valid, main_valid_d;
   logic               skid_valid, skid_valid_d;
   logic [D_WIDTH-1:0] main_data, main_data_d;
   logic [D_WIDTH-1:0] skid_data, skid_data_d;

   sync_2ff #(.WIDTH(P_SIZE)) u_rd_sync (
      .clk  (w_clk),
      .rstn (w_rstn),
      .d    (rd_gray_ptr),
      .q    (sync_rd_ptr)
   );

   assign rd_bin     = P_SIZE'(gray2bin(ptr_t'(sync_rd_ptr)));
   assign lvl        = w_ptr - rd_bin;
   // The level gate covers the cycle where full still lags w_ptr.
   assign w_inc      = main_valid && !full && (lvl < P_SIZE'(FIFO_DEPTH));
   assign w_data     = main_data;
   assign xfer       = up.s_valid && ready_q;
   assign up.s_ready = ready_q;

   always_comb begin
      main_valid_d = main_valid;
      main_data_d  = main_data;
      skid_valid_d = skid_valid;
      skid_data_d  = skid_data;
      if (w_inc) begin
         if (skid_valid) begin
            main_data_d  = skid_data;
            skid_valid_d = 1'b0;
         end else if (xfer) begin
            main_data_d  = up.s_data;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (xfer) begin
         if (!main_valid) begin
            main_valid_d = 1'b1;
            main_data_d  = up.s_data;
         end else begin
            skid_valid_d = 1'b1;
            skid_data_d  = up.s_data;
         end
      end
   end

   always_ff @(posedge w_clk or negedge w_rstn) begin
      if (!w_rstn) begin
         main_valid  <= 1'b0;
         skid_valid  <= 1'b0;
         ready_q     <= 1'b0;
         w_level     <= '0;
         almost_full <= 1'b0;
         wr_count    <= '0;
      end else begin
         main_valid  <= main_valid_d;
         skid_valid  <= skid_valid_d;
         ready_q     <= !skid_valid_d;
         w_level     <= lvl;
         almost_full <= (lvl >= P_SIZE'(AF_LEVEL));
         if (w_inc && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
         end
      end
   end

   always_ff @(posedge w_clk) begin
      main_data <= main_data_d;
      skid_data <= skid_data_d;
   end
endmodule

// File: tb/tb_fifo_wr_ingress.sv
// Directed bench for fifo_wr_ingress with a lagging-full write-pointer model.
module tb_fifo_wr_ingress;
   logic       w_clk = 1'b0;
   logic       w_rstn = 1'b0;
   logic [3:0] rd_gray_ptr = 4'd0;
   logic [3:0] w_ptr;
   logic       full;
   logic [3:0] sync_rd_ptr;
   logic       w_inc;
   logic [7:0] w_data;
   logic [3:0] w_level;
   logic       almost_full;
   logic [15:0] wr_count;

   int checks = 0;
   int failures = 0;

   logic [7:0] log_data [0:63];
   logic [3:0] log_ptr  [0:63];
   int         log_n = 0;
   logic       winc_at_full = 1'b0;
   logic [3:0] m_wptr;
   logic       m_full;

   fifo_wr_ingress_if #(.D_WIDTH(8)) up_if ();

   fifo_wr_ingress #(.P_SIZE(4), .D_WIDTH(8), .AF_LEVEL(6)) dut (
      .w_clk       (w_clk),
      .w_rstn      (w_rstn),
      .up          (up_if),
      .rd_gray_ptr (rd_gray_ptr),
      .w_ptr       (w_ptr),
      .full        (full),
      .sync_rd_ptr (sync_rd_ptr),
      .w_inc       (w_inc),
      .w_data      (w_data),
      .w_level     (w_level),
      .almost_full (almost_full),
      .wr_count    (wr_count)
   );

   always #5 w_clk = ~w_clk;

   function automatic logic [3:0] g2b(input logic [3:0] g);
      logic [3:0] b;
      b[3] = g[3];
      b[2] = g[3] ^ g[2];
      b[1] = g[3] ^ g[2] ^ g[1];
      b[0] = g[3] ^ g[2] ^ g[1] ^ g[0];
      return b;
   endfunction

   function automatic logic [3:0] b2g(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   // Write-pointer block model: full is registered from the old w_ptr.
   assign w_ptr = m_wptr;
   assign full  = m_full;
   always @(posedge w_clk or negedge w_rstn) begin
      if (!w_rstn) begin
         m_wptr <= 4'd0;
         m_full <= 1'b0;
      end else begin
         if (w_inc) begin
            m_wptr <= m_wptr + 4'd1;
            log_data[log_n] <= w_data;
            log_ptr[log_n]  <= m_wptr;
            log_n <= log_n + 1;
            if ((m_wptr - g2b(sync_rd_ptr)) == 4'd8) winc_at_full <= 1'b1;
         end
         m_full <= ((m_wptr - g2b(sync_rd_ptr)) == 4'd8);
      end
   end

   task automatic offer(input logic [7:0] d, output bit acc);
      @(negedge w_clk);
      up_if.s_valid = 1'b1;
      up_if.s_data  = d;
      acc = up_if.s_ready;
      @(posedge w_clk);
   endtask

   task automatic send_word(input logic [7:0] d);
      bit acc;
      int n;
      n = 0;
      do begin
         offer(d, acc);
         n++;
      end while (!acc && n < 20);
      if (!acc) begin
         checks++; failures++;
         $display("FAIL send_timeout word=%0h not accepted within 20 cycles", d);
      end
      #1 up_if.s_valid = 1'b0;
   endtask

   task automatic test_reset();
      up_if.s_valid = 1'b0;
      up_if.s_data  = 8'h00;
      w_rstn = 1'b0;
      repeat (2) @(negedge w_clk);
      checks++; if (up_if.s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%0b exp=0", up_if.s_ready); end
      checks++; if (w_inc !== 1'b0) begin failures++; $display("FAIL rst_w_inc got=%0b exp=0", w_inc); end
      checks++; if (w_level !== 4'd0) begin failures++; $display("FAIL rst_w_level got=%0d exp=0", w_level); end
      checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL rst_almost_full got=%0b exp=0", almost_full); end
      checks++; if (wr_count !== 16'd0) begin failures++; $display("FAIL rst_wr_count got=%0d exp=0", wr_count); end
      checks++; if (sync_rd_ptr !== 4'd0) begin failures++; $display("FAIL rst_sync got=%0h exp=0", sync_rd_ptr); end
      w_rstn = 1'b1;
      #1;
      checks++; if (up_if.s_ready !== 1'b0) begin failures++; $display("FAIL rel_s_ready_before_edge got=%0b exp=0", up_if.s_ready); end
      @(negedge w_clk);
      checks++; if (up_if.s_ready !== 1'b1) begin failures++; $display("FAIL rel_s_ready_first_edge got=%0b exp=1", up_if.s_ready); end
   endtask

   task automatic test_fill();
      int base, idx;
      bit acc, af_seen;
      base = log_n; idx = 0; af_seen = 0;
      repeat (30) begin
         @(negedge w_clk);
         if (almost_full && !af_seen) begin
            af_seen = 1;
            checks++; if (w_level !== 4'd6) begin failures++; $display("FAIL af_rise_level got=%0d exp=6", w_level); end
         end
         up_if.s_valid = 1'b1;
         up_if.s_data  = 8'hA0 + 8'(idx);
         acc = up_if.s_ready;
         @(posedge w_clk);
         if (acc) idx++;
      end
      @(negedge w_clk);
      checks++; if (af_seen !== 1'b1) begin failures++; $display("FAIL af_never_rose got=%0b exp=1", af_seen); end
      checks++; if (idx != 10) begin failures++; $display("FAIL fill_accepted got=%0d exp=10", idx); end
      checks++; if (log_n - base != 8) begin failures++; $display("FAIL fill_w_inc_count got=%0d exp=8", log_n - base); end
      checks++; if (w_level !== 4'd8) begin failures++; $display("FAIL fill_w_level got=%0d exp=8", w_level); end
      checks++; if (almost_full !== 1'b1) begin failures++; $display("FAIL fill_almost_full got=%0b exp=1", almost_full); end
      checks++; if (up_if.s_ready !== 1'b0) begin failures++; $display("FAIL fill_s_ready got=%0b exp=0", up_if.s_ready); end
      checks++; if (wr_count !== 16'd8) begin failures++; $display("FAIL fill_wr_count got=%0d exp=8", wr_count); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (log_data[base+i] !== 8'hA0 + 8'(i)) begin failures++; $display("FAIL fill_data[%0d] got=%0h exp=%0h", i, log_data[base+i], 8'hA0 + 8'(i)); end
      end
      checks++; if (winc_at_full !== 1'b0) begin failures++; $display("FAIL fill_winc_at_full got=%0b exp=0", winc_at_full); end
   endtask

   task automatic test_drain_one();
      int base;
      base = log_n;
      rd_gray_ptr = 4'b0001;
      @(posedge w_clk);
      @(negedge w_clk);
      checks++; if (sync_rd_ptr !== 4'd0) begin failures++; $display("FAIL sync_after_1 got=%0h exp=0", sync_rd_ptr); end
      @(posedge w_clk);
      @(negedge w_clk);
      checks++; if (sync_rd_ptr !== 4'd1) begin failures++; $display("FAIL sync_after_2 got=%0h exp=1", sync_rd_ptr); end
      repeat (8) @(negedge w_clk);
      checks++; if (log_n - base != 1) begin failures++; $display("FAIL drain_w_inc_count got=%0d exp=1", log_n - base); end
      checks++; if (log_data[base] !== 8'hA8) begin failures++; $display("FAIL drain_data got=%0h exp=a8", log_data[base]); end
      checks++; if (log_ptr[base] !== 4'd8) begin failures++; $display("FAIL drain_ptr got=%0d exp=8", log_ptr[base]); end
      checks++; if (w_level !== 4'd8) begin failures++; $display("FAIL drain_w_level got=%0d exp=8", w_level); end
      checks++; if (winc_at_full !== 1'b0) begin failures++; $display("FAIL drain_winc_at_full got=%0b exp=0", winc_at_full); end
      checks++; if (up_if.s_ready !== 1'b0) begin failures++; $display("FAIL drain_s_ready got=%0b exp=0", up_if.s_ready); end
   endtask

   task automatic test_reset_discard();
      int base;
      bit acc;
      @(negedge w_clk);
      w_rstn = 1'b0;
      up_if.s_valid = 1'b0;
      rd_gray_ptr = 4'd0;
      #1;
      checks++; if (up_if.s_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_s_ready got=%0b exp=0", up_if.s_ready); end
      checks++; if (w_inc !== 1'b0) begin failures++; $display("FAIL mid_rst_w_inc got=%0b exp=0", w_inc); end
      checks++; if (wr_count !== 16'd0) begin failures++; $display("FAIL mid_rst_wr_count got=%0d exp=0", wr_count); end
      checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL mid_rst_almost_full got=%0b exp=0", almost_full); end
      repeat (2) @(negedge w_clk);
      w_rstn = 1'b1;
      base = log_n;
      offer(8'hB0, acc);
      if (!acc) offer(8'hB0, acc);
      #1 up_if.s_valid = 1'b0;
      @(negedge w_clk);
      checks++; if (w_inc !== 1'b1 || w_data !== 8'hB0) begin failures++; $display("FAIL latency_1 got w_inc=%0b w_data=%0h exp w_inc=1 w_data=b0", w_inc, w_data); end
      send_word(8'hB1);
      send_word(8'hB2);
      repeat (4) @(negedge w_clk);
      checks++; if (log_n - base != 3) begin failures++; $display("FAIL discard_count got=%0d exp=3", log_n - base); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (log_data[base+i] !== 8'hB0 + 8'(i) || log_ptr[base+i] !== 4'(i)) begin
            failures++; $display("FAIL discard_entry[%0d] got data=%0h ptr=%0d exp data=%0h ptr=%0d", i, log_data[base+i], log_ptr[base+i], 8'hB0 + 8'(i), i);
         end
      end
      checks++; if (wr_count !== 16'd3) begin failures++; $display("FAIL discard_wr_count got=%0d exp=3", wr_count); end
      checks++; if (w_level !== 4'd3) begin failures++; $display("FAIL discard_w_level got=%0d exp=3", w_level); end
   endtask

   task automatic test_wrap();
      int base;
      @(negedge w_clk);
      w_rstn = 1'b0;
      rd_gray_ptr = 4'd0;
      repeat (2) @(negedge w_clk);
      w_rstn = 1'b1;
      base = log_n;
      for (int k = 0; k < 3; k++) send_word(8'h40 + 8'(k));
      repeat (4) @(negedge w_clk);
      checks++; if (w_level !== 4'd3) begin failures++; $display("FAIL wrap_level_init got=%0d exp=3", w_level); end
      for (int k = 3; k < 20; k++) begin
         @(negedge w_clk);
         rd_gray_ptr = b2g(4'(k - 2));
         send_word(8'h40 + 8'(k));
         repeat (6) @(negedge w_clk);
         checks++; if (w_level !== 4'd3) begin failures++; $display("FAIL wrap_level[%0d] got=%0d exp=3", k, w_level); end
      end
      checks++; if (log_n - base != 20) begin failures++; $display("FAIL wrap_count got=%0d exp=20", log_n - base); end
      checks++; if (wr_count !== 16'd20) begin failures++; $display("FAIL wrap_wr_count got=%0d exp=20", wr_count); end
      for (int i = 0; i < 20; i++) begin
         checks++; if (log_data[base+i] !== 8'h40 + 8'(i)) begin failures++; $display("FAIL wrap_data[%0d] got=%0h exp=%0h", i, log_data[base+i], 8'h40 + 8'(i)); end
      end
      checks++; if (log_ptr[base+15] !== 4'd15 || log_ptr[base+16] !== 4'd0) begin
         failures++; $display("FAIL wrap_ptr got=%0d,%0d exp=15,0", log_ptr[base+15], log_ptr[base+16]);
      end
      checks++; if (winc_at_full !== 1'b0) begin failures++; $display("FAIL wrap_winc_at_full got=%0b exp=0", winc_at_full); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain_one();
      test_reset_discard();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not complete by 100000 time units");
      $fatal(1);
   end
endmodule
